// File: rtl/mem_lsu_if.sv
// CPU-side request/response channel of the load/store unit.
// The CPU drives requests as master; mem_lsu answers as slave.
interface mem_lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_rt_old;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rt_old,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rt_old,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lsu.sv
// MIPS load/store unit: maps byte/half/word/unaligned accesses onto a word-wide,
// big-endian memory with 1-cycle read latency (read-modify-write for SB/SH).
module mem_lsu #(
    parameter int ADDR_W   = 32,
    parameter bit CHECK_AL = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_lsu_if.slave          bus,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_write,
    output logic [31:0]       data_writedata,
    input  logic [31:0]       data_readdata
);

    typedef enum logic [3:0] {
        OP_LB  = 4'd0, OP_LBU = 4'd1, OP_LH  = 4'd2, OP_LHU = 4'd3,
        OP_LW  = 4'd4, OP_LWL = 4'd5, OP_LWR = 4'd6,
        OP_SB  = 4'd8, OP_SH  = 4'd9, OP_SW  = 4'd10
    } op_e;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DATA, S_WRITE, S_RESP_ERR} state_e;

    state_e            state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rt_q;
    logic              ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_out_q;

    logic              req_legal;
    logic              req_misal;
    logic              req_err;
    logic [ADDR_W-1:0] req_addr_fix;
    logic [ADDR_W-1:0] req_word_addr;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        req_legal    = 1'b1;
        req_misal    = 1'b0;
        req_addr_fix = bus.req_addr;
        case (bus.req_op)
            OP_LH, OP_LHU, OP_SH:                  req_misal = bus.req_addr[0];
            OP_LW, OP_SW:                          req_misal = |bus.req_addr[1:0];
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB:  req_misal = 1'b0;
            default:                               req_legal = 1'b0;
        endcase
        if (req_misal && !CHECK_AL) req_addr_fix[1:0] = 2'b00;
        req_err       = !req_legal || (CHECK_AL && req_misal);
        req_word_addr = {req_addr_fix[ADDR_W-1:2], 2'b00};
    end

    // Big-endian lanes: offset k sits (3-k) bytes above bit 0; ~k equals 3-k for 2 bits.
    logic [1:0]  k;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] rd_byte;
    logic [31:0] rd_half;
    logic [31:0] load_result;
    logic [31:0] store_merge;
    logic [31:0] lane_mask;

    always_comb begin
        k           = addr_q[1:0];
        byte_sh     = {~k, 3'b000};
        half_sh     = {~k[1], 4'b0000};
        rd_byte     = data_readdata >> byte_sh;
        rd_half     = data_readdata >> half_sh;
        load_result = '0;
        case (op_q)
            OP_LB:   load_result = {{24{rd_byte[7]}}, rd_byte[7:0]};
            OP_LBU:  load_result = {24'h0, rd_byte[7:0]};
            OP_LH:   load_result = {{16{rd_half[15]}}, rd_half[15:0]};
            OP_LHU:  load_result = {16'h0, rd_half[15:0]};
            OP_LW:   load_result = data_readdata;
            OP_LWL:  load_result = (data_readdata << {k, 3'b000})
                                 | (rt_q & ((32'h1 << {k, 3'b000}) - 32'h1));
            OP_LWR:  load_result = (data_readdata >> byte_sh)
                                 | (rt_q & ~(32'hFFFF_FFFF >> byte_sh));
            default: load_result = '0;
        endcase

        if (op_q == OP_SH) begin
            lane_mask   = 32'h0000_FFFF << half_sh;
            store_merge = (data_readdata & ~lane_mask) | ({16'h0, wdata_q[15:0]} << half_sh);
        end else begin
            lane_mask   = 32'h0000_00FF << byte_sh;
            store_merge = (data_readdata & ~lane_mask) | ({24'h0, wdata_q[7:0]} << byte_sh);
        end
    end

    // op_q[3] separates stores (8..10) from loads (0..6) once a request is known legal.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rt_q         <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            write_q      <= 1'b0;
            addr_out_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            write_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        addr_q  <= req_addr_fix;
                        wdata_q <= bus.req_wdata;
                        rt_q    <= bus.req_rt_old;
                        ready_q <= 1'b0;
                        if (req_err) begin
                            state_q      <= S_RESP_ERR;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_op == OP_SW) begin
                            state_q      <= S_WRITE;
                            write_q      <= 1'b1;
                            resp_valid_q <= 1'b1;
                            addr_out_q   <= req_word_addr;
                        end else begin
                            state_q    <= S_READ;
                            addr_out_q <= req_word_addr;
                        end
                    end
                end
                S_READ: begin
                    state_q      <= S_DATA;
                    resp_valid_q <= ~op_q[3];
                end
                S_DATA: begin
                    if (!op_q[3]) begin
                        state_q    <= S_IDLE;
                        ready_q    <= 1'b1;
                        addr_out_q <= '0;
                    end else begin
                        wdata_q      <= store_merge;
                        state_q      <= S_WRITE;
                        write_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    ready_q    <= 1'b1;
                    addr_out_q <= '0;
                end
            endcase
        end
    end

    // The write strobe is gated by reset_n so a reset landing in WRITE blocks the store.
    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = (resp_valid_q && !resp_err_q && !op_q[3]) ? load_result : 32'h0;
    assign data_address    = addr_out_q;
    assign data_write      = write_q & reset_n;
    assign data_writedata  = write_q ? wdata_q : 32'h0;

endmodule
